// File: rtl/alu_op_sequencer_if.sv
// Bus between the control unit / instruction bus and alu_op_sequencer.
// The master drives the decoded instruction fields and MDU done; the slave is the sequencer.
interface alu_op_sequencer_if #(
  parameter int unsigned OP_W = 5
);
  logic            valid_i;
  logic [6:0]      funct7_i;
  logic [2:0]      ALU_Op_i;
  logic [2:0]      funct3_i;
  logic            md_done_i;
  logic [OP_W-1:0] ALU_Operation_o;
  logic            md_start_o;
  logic [2:0]      md_op_o;
  logic            stall_o;
  logic            result_sel_o;
  logic            error_o;

  modport master (
    output valid_i, funct7_i, ALU_Op_i, funct3_i, md_done_i,
    input  ALU_Operation_o, md_start_o, md_op_o, stall_o, result_sel_o, error_o
  );

  modport slave (
    input  valid_i, funct7_i, ALU_Op_i, funct3_i, md_done_i,
    output ALU_Operation_o, md_start_o, md_op_o, stall_o, result_sel_o, error_o
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// RV32I ALU operation decoder with an optional multi-cycle RV32M sequencer.
// Macro ALU_SEQ_MDU_EN compiles in the MDU launch/stall FSM; without it M-ops decode as ADD.
module alu_op_sequencer #(
  parameter int unsigned OP_W       = 5,
  parameter int unsigned MD_TIMEOUT = 40
) (
  input logic                clk,
  input logic                reset,
  alu_op_sequencer_if.slave  io_bus
);

  localparam logic [3:0] OpAdd   = 4'd0;
  localparam logic [3:0] OpSub   = 4'd1;
  localparam logic [3:0] OpPassB = 4'd2;
  localparam logic [3:0] OpAnd   = 4'd3;
  localparam logic [3:0] OpOr    = 4'd4;
  localparam logic [3:0] OpXor   = 4'd5;
  localparam logic [3:0] OpSll   = 4'd6;
  localparam logic [3:0] OpSrl   = 4'd7;
  localparam logic [3:0] OpSra   = 4'd8;
  localparam logic [3:0] OpSlt   = 4'd9;
  localparam logic [3:0] OpSltu  = 4'd10;
`ifdef ALU_SEQ_MDU_EN
  localparam logic [3:0] OpMdu   = 4'd15;
`endif

  logic [3:0] w_f3_op;
  logic [3:0] w_op;

  // Shared funct3 map of the base R-type/I-type integer ops.
  always_comb begin
    w_f3_op = OpAdd;
    case (io_bus.funct3_i)
      3'b000:  w_f3_op = OpAdd;
      3'b001:  w_f3_op = OpSll;
      3'b010:  w_f3_op = OpSlt;
      3'b011:  w_f3_op = OpSltu;
      3'b100:  w_f3_op = OpXor;
      3'b101:  w_f3_op = OpSrl;
      3'b110:  w_f3_op = OpOr;
      default: w_f3_op = OpAnd;
    endcase
  end

  always_comb begin
    w_op = OpAdd;
    case (io_bus.ALU_Op_i)
      3'b000: begin
        if (io_bus.funct7_i == 7'b0000000) begin
          w_op = w_f3_op;
        end else if (io_bus.funct7_i == 7'b0100000) begin
          if (io_bus.funct3_i == 3'b000) w_op = OpSub;
          else if (io_bus.funct3_i == 3'b101) w_op = OpSra;
`ifdef ALU_SEQ_MDU_EN
        end else if (io_bus.funct7_i == 7'b0000001) begin
          w_op = OpMdu;
`endif
        end
      end
      3'b001: begin
        if (io_bus.funct3_i == 3'b000) w_op = OpAdd;
        else if (io_bus.funct3_i == 3'b101)
          w_op = (io_bus.funct7_i == 7'b0100000) ? OpSra : OpSrl;
        else w_op = w_f3_op;
      end
      3'b011: begin
        case (io_bus.funct3_i[2:1])
          2'b00:   w_op = OpSub;
          2'b10:   w_op = OpSlt;
          2'b11:   w_op = OpSltu;
          default: w_op = OpAdd;
        endcase
      end
      3'b111:  w_op = OpPassB;
      default: w_op = OpAdd;
    endcase
  end

  assign io_bus.ALU_Operation_o = OP_W'(w_op);

`ifdef ALU_SEQ_MDU_EN
  localparam int unsigned CntW = $clog2(MD_TIMEOUT + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [CntW-1:0] r_cnt;
  logic            r_md_start;
  logic [2:0]      r_md_op;
  logic            r_error;
  logic            w_is_mop;
  logic            w_launch;
  logic            w_timeout;
  logic            w_stall;
  logic            w_result_sel;

  assign w_is_mop = (io_bus.ALU_Op_i == 3'b000) && (io_bus.funct7_i == 7'b0000001);

  always_comb begin
    w_state_nxt  = r_state;
    w_launch     = 1'b0;
    w_timeout    = 1'b0;
    w_stall      = 1'b0;
    w_result_sel = 1'b0;
    case (r_state)
      StIdle: begin
        if (io_bus.valid_i && w_is_mop) begin
          w_stall     = 1'b1;
          w_launch    = 1'b1;
          w_state_nxt = StWait;
        end
      end
      StWait: begin
        w_stall = 1'b1;
        // done takes priority over a simultaneous timeout
        if (io_bus.md_done_i) begin
          w_state_nxt = StDone;
        end else if (r_cnt == CntW'(MD_TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        w_result_sel = 1'b1;
        w_state_nxt  = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_md_start <= 1'b0;
      r_md_op    <= 3'b000;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_md_start <= w_launch;
      if (w_launch) begin
        r_md_op <= io_bus.funct3_i;
        r_cnt   <= '0;
      end else if (r_state == StWait) begin
        r_cnt <= r_cnt + CntW'(1);
      end
      if (w_timeout) r_error <= 1'b1;
    end
  end

  assign io_bus.md_start_o   = r_md_start;
  assign io_bus.md_op_o      = r_md_op;
  assign io_bus.stall_o      = w_stall;
  assign io_bus.result_sel_o = w_result_sel;
  assign io_bus.error_o      = r_error;
`else
  logic w_unused;
  assign w_unused = ^{clk, reset, io_bus.valid_i, io_bus.md_done_i};

  assign io_bus.md_start_o   = 1'b0;
  assign io_bus.md_op_o      = 3'b000;
  assign io_bus.stall_o      = 1'b0;
  assign io_bus.result_sel_o = 1'b0;
  assign io_bus.error_o      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer; follows ALU_SEQ_MDU_EN to pick expectations.
module tb_alu_op_sequencer;

  localparam int unsigned OpW       = 5;
  localparam int unsigned MdTimeout = 40;
`ifdef ALU_SEQ_MDU_EN
  localparam bit MduEn = 1'b1;
`else
  localparam bit MduEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.OP_W(OpW)) bus ();

  alu_op_sequencer #(
    .OP_W       (OpW),
    .MD_TIMEOUT (MdTimeout)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  typedef struct packed {
    logic [OpW-1:0] op;
    logic           stall;
    logic           start;
    logic [2:0]     md_op;
    logic           rsel;
    logic           err;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [2:0]  last_md_op;
  logic        err_sticky;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [3:0] model_op(input logic [6:0] f7, input logic [2:0] aop,
                                          input logic [2:0] f3);
    logic [3:0] base [8];
    base = '{4'd0, 4'd6, 4'd9, 4'd10, 4'd5, 4'd7, 4'd4, 4'd3};
    case (aop)
      3'd0: begin
        if (f7 == 7'h00) return base[f3];
        if (f7 == 7'h20) return (f3 == 3'd0) ? 4'd1 : (f3 == 3'd5) ? 4'd8 : 4'd0;
        if (f7 == 7'h01) return MduEn ? 4'd15 : 4'd0;
        return 4'd0;
      end
      3'd1: begin
        if (f3 == 3'd0) return 4'd0;
        if (f3 == 3'd5) return (f7 == 7'h20) ? 4'd8 : 4'd7;
        return base[f3];
      end
      3'd3: begin
        if (f3 < 3'd2) return 4'd1;
        if (f3 == 3'd4 || f3 == 3'd5) return 4'd9;
        if (f3 >= 3'd6) return 4'd10;
        return 4'd0;
      end
      3'd7:    return 4'd2;
      default: return 4'd0;
    endcase
  endfunction

  // One clock cycle: drive after the edge, push the expectation, compare at the falling edge.
  task automatic step(input string tag, input logic rst, input logic v, input logic [6:0] f7,
                      input logic [2:0] aop, input logic [2:0] f3, input logic done,
                      input bit chk, input logic stall, input logic start, input logic rsel);
    exp_t e;
    @(posedge clk);
    #1;
    reset          = rst;
    bus.valid_i    = v;
    bus.funct7_i   = f7;
    bus.ALU_Op_i   = aop;
    bus.funct3_i   = f3;
    bus.md_done_i  = done;
    if (chk) begin
      exp_q.push_back('{op: OpW'(model_op(f7, aop, f3)), stall: stall & MduEn,
                        start: start & MduEn, md_op: last_md_op, rsel: rsel & MduEn,
                        err: err_sticky});
    end
    @(negedge clk);
    if (chk) begin
      if (exp_q.size() == 0) begin
        check_eq({tag, ".queue"}, 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq({tag, ".op"},    32'(bus.ALU_Operation_o), 32'(e.op));
        check_eq({tag, ".stall"}, 32'(bus.stall_o),         32'(e.stall));
        check_eq({tag, ".start"}, 32'(bus.md_start_o),      32'(e.start));
        check_eq({tag, ".md_op"}, 32'(bus.md_op_o),         32'(e.md_op));
        check_eq({tag, ".rsel"},  32'(bus.result_sel_o),    32'(e.rsel));
        check_eq({tag, ".err"},   32'(bus.error_o),         32'(e.err));
      end
    end
  endtask

  // M-op with md_done_i in WAIT cycle n_done (0: never, so it times out).
  task automatic run_mop(input string tag, input logic [2:0] f3, input int n_done);
    bit got_done = 1'b0;
    step({tag, ".idle"}, 1'b0, 1'b1, 7'h01, 3'd0, f3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    last_md_op = MduEn ? f3 : 3'd0;
    for (int k = 1; k <= int'(MdTimeout); k++) begin
      got_done = (k == n_done);
      step($sformatf("%s.wait%0d", tag, k), 1'b0, 1'b1, 7'h01, 3'd0, f3, got_done, 1'b1,
           1'b1, k == 1, 1'b0);
      if (got_done) break;
    end
    if (!got_done) err_sticky = MduEn;
    step({tag, ".done"}, 1'b0, 1'b1, 7'h01, 3'd0, f3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step({tag, ".after"}, 1'b0, 1'b0, 7'h00, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [6:0] f7_list [4];
    f7_list    = '{7'h00, 7'h20, 7'h01, 7'h7F};
    last_md_op = 3'd0;
    err_sticky = 1'b0;
    reset          = 1'b1;
    bus.valid_i    = 1'b0;
    bus.funct7_i   = 7'h00;
    bus.ALU_Op_i   = 3'd0;
    bus.funct3_i   = 3'd0;
    bus.md_done_i  = 1'b0;

    step("rst0", 1'b1, 1'b0, 7'h00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rst",  1'b1, 1'b0, 7'h00, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Decode sweep; the funct7=0000001 row is driven with valid low so nothing launches.
    for (int i = 0; i < 4; i++) begin
      for (int a = 0; a < 8; a++) begin
        for (int f = 0; f < 8; f++) begin
          step($sformatf("dec.f7_%0h.op%0d.f3_%0d", f7_list[i], a, f), 1'b0,
               f7_list[i] != 7'h01, f7_list[i], 3'(a), 3'(f), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
      end
    end

    step("stray0", 1'b0, 1'b0, 7'h00, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("stray1", 1'b0, 1'b0, 7'h00, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    run_mop("div5",    3'b100, 5);
    run_mop("mul1",    3'b000, 1);
    run_mop("rem40",   3'b110, int'(MdTimeout));
    run_mop("timeout", 3'b101, 0);

    // Reset in WAIT cycle 3, then a plain ADD must not stall.
    step("rw.idle", 1'b0, 1'b1, 7'h01, 3'd0, 3'b011, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    last_md_op = MduEn ? 3'b011 : 3'd0;
    step("rw.wait1", 1'b0, 1'b1, 7'h01, 3'd0, 3'b011, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step("rw.wait2", 1'b0, 1'b1, 7'h01, 3'd0, 3'b011, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("rw.wait3", 1'b1, 1'b1, 7'h01, 3'd0, 3'b011, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    last_md_op = 3'd0;
    err_sticky = 1'b0;
    step("rw.add",  1'b0, 1'b1, 7'h00, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("rw.idle2", 1'b0, 1'b0, 7'h00, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
